resp_framer: RTL
================

# resp_framer

Response-path framer between `cmd_dispatcher` and the UART transmit byte FIFO. It is the counterpart of `cmd_parser`: `cmd_parser` turns received bytes into command packets, and this block turns dispatcher responses into transmitted byte frames. It buffers each dispatcher response (`data_out_tx`/`out_tx_en`, plus an error flag) in a small internal queue. It then serialises each entry as a fixed 4-byte frame into the TX byte FIFO, with stall-tolerant write handshaking.

## Interface
Parameters:
- `DEPTH`, 8: response queue entries; power of two, ≥2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: queue pointer width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `resp_en`  in  1  one-cycle strobe from dispatcher (`out_tx_en`): push one response.
- `resp_data`  in  8  response payload (`data_out_tx`), sampled when `resp_en`=1.
- `resp_err`  in  1  response is an error, sampled when `resp_en`=1.
- `tx_fifo_full`  in  1  TX byte FIFO cannot accept a byte this cycle.
- `tx_fifo_wr_en`  out  1  write strobe to TX byte FIFO.
- `tx_fifo_wr_data`  out  8  byte to write.
- `resp_full`  out  1  queue holds `DEPTH` entries.
- `resp_overflow`  out  1  sticky: a push was dropped; cleared only by `rst`.
- `busy`  out  1  FSM not in IDLE, or queue non-empty.

## Operation
- Frame, in order:
  - SOF = 8'hA5.
  - STATUS = 8'h00 (ok) or 8'hEE (`resp_err`=1).
  - DATA = `resp_data`.
  - CHK = STATUS ^ DATA.
- Queue push: `resp_en`=1 and not `resp_full` writes {err, data}.
- Push when full is dropped and sets `resp_overflow`, even if a pop occurs the same cycle.
- FSM states: IDLE, SOF, STAT, DATA, CHK.
- IDLE → SOF when the queue is non-empty. The head entry is popped into the hold register on this transition.
- SOF → STAT → DATA → CHK: each advance occurs only on a byte accept, i.e. `tx_fifo_wr_en`=1 (`tx_fifo_full`=0).
- CHK on accept:
  - queue non-empty → pop head into hold, go to SOF (back-to-back frames, no gap);
  - queue empty → IDLE.
- Outputs:
  - `tx_fifo_wr_en` = (state≠IDLE) & ~`tx_fifo_full`. This is a combinational path from `tx_fifo_full`.
  - `tx_fifo_wr_data` is a mux of state and hold register; it stays stable while stalled.
- Stall: while `tx_fifo_full`=1 the state and hold register are frozen; no byte is skipped or duplicated.
- Simultaneous push and pop with the queue not full: both occur; count unchanged.
- Push into an empty queue while in IDLE: the entry becomes visible the next cycle (no bypass).
- Checksum is 8-bit XOR; no carry or width growth.

## Timing
- Reset values:
  - state IDLE, queue empty, hold = 0;
  - `tx_fifo_wr_en`=0, `tx_fifo_wr_data`=8'h00;
  - `resp_full`=0, `resp_overflow`=0, `busy`=0.
- Latency with no stall, `resp_en` in cycle 0:
  - cycle 1: IDLE pops;
  - cycles 2–5: SOF, STAT, DATA, CHK written one per cycle.
- Throughput: 4 cycles per frame when continuously fed and never stalled.
- `resp_full`/`busy` are registered-state-derived and reflect the queue count after the previous edge.
- `rst` mid-frame: the partial frame is abandoned (never resumed), the queue is flushed, and `tx_fifo_wr_en` deasserts in the cycle after the reset edge.

## Structure
- Package `resp_pkg`:
  - `resp_entry_t` (packed {err, data[7:0]});
  - `RESP_SOF`=8'hA5, `RESP_OK`=8'h00, `RESP_ERR`=8'hEE;
  - FSM state enum `resp_state_t`.
- One sub-module, `resp_fifo`:
  - synchronous FIFO of `resp_entry_t`, parameters `DEPTH`/`ADDR_WIDTH`;
  - wrap-around pointers plus a count of width `ADDR_WIDTH`+1;
  - outputs `full`/`empty`;
  - first-word-fall-through read data.
- Top level: FSM, hold register, output mux, overflow flag.

## Test plan
- Ok response: `resp_en` with `resp_data`=8'h3C, `resp_err`=0, `tx_fifo_full`=0 → bytes A5 00 3C 3C in cycles 2–5; `busy` drops after CHK.
- Error response: `resp_data`=8'h00, `resp_err`=1 → A5 EE 00 EE.
- Back-to-back: 3 pushes (11, 22, 33) in consecutive cycles → 12 contiguous writes A5 00 11 11 A5 00 22 22 A5 00 33 33 with no idle cycle.
- Stall: `tx_fifo_full`=1 for 3 cycles while in DATA (`resp_data`=8'h5A) → `tx_fifo_wr_en`=0 with `tx_fifo_wr_data` held at 5A; then 5A, 5A written exactly once each (DATA, then CHK).
- Overflow: `tx_fifo_full` held high, 10 pushes with `DEPTH`=8.
  - The first push is popped into hold, so 9 are accepted and `resp_full` asserts.
  - The last push is dropped and `resp_overflow`=1.
  - After releasing full, exactly 9 correct frames are emitted and `resp_overflow` stays 1.
- Reset mid-frame: assert `rst` during STAT of a frame with 2 entries still queued → all outputs at reset values the next cycle; no further bytes after `rst` is released.

Source files
------------

// File: rtl/resp_pkg.sv
// rtl/resp_pkg.sv - shared types and constants for the response framer
//
// Purpose: response queue entry layout, frame byte constants and the
//          framer FSM state encoding.
// Ports:   none (package).

package resp_pkg;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } resp_entry_t;

   localparam int RESP_ENTRY_W = $bits(resp_entry_t);

   localparam logic [7:0] RESP_SOF = 8'hA5;
   localparam logic [7:0] RESP_OK  = 8'h00;
   localparam logic [7:0] RESP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_STAT,
      ST_DATA,
      ST_CHK
   } resp_state_t;

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - synchronous first-word-fall-through response queue
//
// Purpose: holds pending dispatcher responses until the framer takes them.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    push request and entry (ignored when full)
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry, valid whenever empty = 0
//   full, empty       occupancy flags from the registered count

module resp_fifo
   import resp_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [RESP_ENTRY_W-1:0] wr_data,
   input  logic                    rd_en,
   output logic [RESP_ENTRY_W-1:0] rd_data,
   output logic                    full,
   output logic                    empty
);

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

   resp_entry_t             mem [DEPTH];
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0]   rd_ptr;
   logic [ADDR_WIDTH:0]     count;
   logic                    push;
   logic                    pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push    = wr_en & ~full;
   assign pop     = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= resp_entry_t'(wr_data);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/resp_framer.sv
// rtl/resp_framer.sv - queues dispatcher responses and emits 4-byte frames
//
// Purpose: buffers responses and serialises each as A5, STATUS, DATA,
//          STATUS^DATA into the TX byte FIFO, freezing while it is full.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   resp_en               one-cycle push strobe from the dispatcher
//   resp_data, resp_err   response payload and error flag
//   tx_fifo_full          TX byte FIFO cannot take a byte this cycle
//   tx_fifo_wr_en         byte write strobe (combinational from tx_fifo_full)
//   tx_fifo_wr_data       byte being offered
//   resp_full             response queue holds DEPTH entries
//   resp_overflow         sticky: a push was dropped since reset
//   busy                  a frame is in progress or responses are queued

module resp_framer
   import resp_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       resp_en,
   input  logic [7:0] resp_data,
   input  logic       resp_err,
   input  logic       tx_fifo_full,
   output logic       tx_fifo_wr_en,
   output logic [7:0] tx_fifo_wr_data,
   output logic       resp_full,
   output logic       resp_overflow,
   output logic       busy
);

   resp_state_t                state;
   resp_state_t                state_nxt;
   resp_entry_t                hold;
   logic [RESP_ENTRY_W-1:0]    q_head;
   logic                       q_empty;
   logic                       q_full;
   logic                       pop;
   logic [7:0]                 status;

   resp_fifo #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (resp_en),
      .wr_data ({resp_err, resp_data}),
      .rd_en   (pop),
      .rd_data (q_head),
      .full    (q_full),
      .empty   (q_empty)
   );

   assign tx_fifo_wr_en = (state != ST_IDLE) & ~tx_fifo_full;
   assign resp_full     = q_full;
   assign busy          = (state != ST_IDLE) | ~q_empty;
   assign status        = hold.err ? RESP_ERR : RESP_OK;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         if (pop) hold <= resp_entry_t'(q_head);
      end
   end

   // The queue's own full flag already refuses the write; a pop in the same
   // cycle does not rescue it, so the drop is recorded here.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_overflow <= 1'b0;
      end else if (resp_en && q_full) begin
         resp_overflow <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!q_empty) begin
               pop       = 1'b1;
               state_nxt = ST_SOF;
            end
         end
         ST_SOF:  if (tx_fifo_wr_en) state_nxt = ST_STAT;
         ST_STAT: if (tx_fifo_wr_en) state_nxt = ST_DATA;
         ST_DATA: if (tx_fifo_wr_en) state_nxt = ST_CHK;
         ST_CHK: begin
            // Chain straight into the next frame so a fed framer never idles.
            if (tx_fifo_wr_en) begin
               if (!q_empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_SOF;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_fifo_wr_data = 8'h00;
      case (state)
         ST_SOF:  tx_fifo_wr_data = RESP_SOF;
         ST_STAT: tx_fifo_wr_data = status;
         ST_DATA: tx_fifo_wr_data = hold.data;
         ST_CHK:  tx_fifo_wr_data = status ^ hold.data;
         default: tx_fifo_wr_data = 8'h00;
      endcase
   end

endmodule
